// File: rtl/div_pkg.sv
// Shared state type and constants for the iterative divider (div_iter_unit).
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_CNT_W  = $clog2(DIV_DATA_W);

  // Divide-by-zero quotient: all ones, or its negation for a negative signed dividend.
  localparam logic [DIV_DATA_W-1:0] DIV_ZERO_LO     = 32'hFFFF_FFFF;
  localparam logic [DIV_DATA_W-1:0] DIV_ZERO_LO_NEG = 32'h0000_0001;

endpackage

// File: rtl/div_iter_unit_if.sv
// Pipeline-side handshake and result bus of the EXE-stage divider.
interface div_iter_unit_if #(
  parameter int DATA_W = 32
);
  logic              EXE_IsDiv;
  logic              EXE_IsSigned;
  logic [DATA_W-1:0] EXE_rs;
  logic [DATA_W-1:0] EXE_rt;
  logic              MEM_Wr;
  logic              Flush_Exception;
  logic              DIVMULTBusy;
  logic              Div_Done;
  logic [DATA_W-1:0] LO_Wdata;
  logic [DATA_W-1:0] HI_Wdata;

  modport master (
    output EXE_IsDiv, EXE_IsSigned, EXE_rs, EXE_rt, MEM_Wr, Flush_Exception,
    input  DIVMULTBusy, Div_Done, LO_Wdata, HI_Wdata
  );

  modport slave (
    input  EXE_IsDiv, EXE_IsSigned, EXE_rs, EXE_rt, MEM_Wr, Flush_Exception,
    output DIVMULTBusy, Div_Done, LO_Wdata, HI_Wdata
  );
endinterface

// File: rtl/div_restore_step.sv
// One combinational restoring-division step on magnitudes: shift {rem,quo} left, try subtract.
module div_restore_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_rem,
  input  logic [DATA_W-1:0] i_quo,
  input  logic [DATA_W-1:0] i_divisor,
  output logic [DATA_W-1:0] o_rem,
  output logic [DATA_W-1:0] o_quo
);
  logic [DATA_W:0] w_shift;
  logic [DATA_W:0] w_trial;

  assign w_shift = {i_rem, i_quo[DATA_W-1]};
  assign w_trial = w_shift - {1'b0, i_divisor};

  // Keep the trial difference only when it did not go negative (bit DATA_W clear).
  always_comb begin
    o_quo = {i_quo[DATA_W-2:0], 1'b0};
    o_rem = w_shift[DATA_W-1:0];
    if (w_trial[DATA_W] == 1'b0) begin
      o_rem    = w_trial[DATA_W-1:0];
      o_quo[0] = 1'b1;
    end else begin
      o_rem    = w_shift[DATA_W-1:0];
    end
  end
endmodule

// File: rtl/div_iter_unit.sv
// Multi-cycle 32-bit DIV/DIVU unit with stall handshake; DIV_ZERO_FAST_EN skips iteration for zero operands.
module div_iter_unit
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  div_iter_unit_if.slave bus
);
  localparam logic [DIV_CNT_W-1:0] LAST_CNT = DIV_CNT_W'(DATA_W - 1);

  div_state_t           r_state;
  logic [DIV_CNT_W-1:0] r_cnt;
  logic [DATA_W-1:0]    r_rem;
  logic [DATA_W-1:0]    r_quo;
  logic [DATA_W-1:0]    r_div;
  logic                 r_qneg;
  logic                 r_rneg;
  logic [DATA_W-1:0]    r_lo;
  logic [DATA_W-1:0]    r_hi;

  logic                 w_start;
  logic [DATA_W-1:0]    w_rem_nx;
  logic [DATA_W-1:0]    w_quo_nx;
  logic [DATA_W-1:0]    w_quo_fix;
  logic [DATA_W-1:0]    w_rem_fix;

  // 0x80000000 maps to itself, which is its correct magnitude read as unsigned.
  function automatic logic [DATA_W-1:0] f_mag(input logic [DATA_W-1:0] v, input logic sgn);
    return (sgn && v[DATA_W-1]) ? (DATA_W'(0) - v) : v;
  endfunction

  assign w_start   = bus.EXE_IsDiv & ~bus.Flush_Exception;
  assign w_quo_fix = r_qneg ? (DATA_W'(0) - w_quo_nx) : w_quo_nx;
  assign w_rem_fix = r_rneg ? (DATA_W'(0) - w_rem_nx) : w_rem_nx;

  div_restore_step #(.DATA_W(DATA_W)) u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_div),
    .o_rem     (w_rem_nx),
    .o_quo     (w_quo_nx)
  );

  // Divider FSM: latch operands, iterate one step per cycle, hold result until retire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_lo    <= '0;
      r_hi    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_rem  <= '0;
            r_cnt  <= '0;
            r_quo  <= f_mag(bus.EXE_rs, bus.EXE_IsSigned);
            r_div  <= f_mag(bus.EXE_rt, bus.EXE_IsSigned);
            r_qneg <= bus.EXE_IsSigned & (bus.EXE_rs[DATA_W-1] ^ bus.EXE_rt[DATA_W-1]);
            r_rneg <= bus.EXE_IsSigned & bus.EXE_rs[DATA_W-1];
`ifdef DIV_ZERO_FAST_EN
            // Same values the full iteration would produce; divisor zero takes priority.
            if (bus.EXE_rt == {DATA_W{1'b0}}) begin
              r_lo    <= (bus.EXE_IsSigned && bus.EXE_rs[DATA_W-1]) ?
                         DATA_W'(DIV_ZERO_LO_NEG) : DATA_W'(DIV_ZERO_LO);
              r_hi    <= bus.EXE_rs;
              r_state <= DONE;
            end else if (bus.EXE_rs == {DATA_W{1'b0}}) begin
              r_lo    <= '0;
              r_hi    <= '0;
              r_state <= DONE;
            end else begin
              r_state <= BUSY;
            end
`else
            r_state <= BUSY;
`endif
          end else begin
            r_state <= IDLE;
          end
        end
        BUSY: begin
          if (bus.Flush_Exception) begin
            r_state <= IDLE;
          end else begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt + DIV_CNT_W'(1);
            if (r_cnt == LAST_CNT) begin
              r_lo    <= w_quo_fix;
              r_hi    <= w_rem_fix;
              r_state <= DONE;
            end else begin
              r_state <= BUSY;
            end
          end
        end
        DONE: begin
          if (bus.Flush_Exception || bus.MEM_Wr) begin
            r_state <= IDLE;
          end else begin
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.DIVMULTBusy = (((r_state == IDLE) & w_start) | (r_state == BUSY)) & ~bus.Flush_Exception;
  assign bus.Div_Done    = (r_state == DONE);
  assign bus.LO_Wdata    = r_lo;
  assign bus.HI_Wdata    = r_hi;
endmodule

// File: tb/tb_div_iter_unit.sv
// Scoreboard bench for div_iter_unit: driver pushes expected LO/HI, monitor checks on each Div_Done rise.
module tb_div_iter_unit;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
  } exp_t;
  exp_t sb_q[$];

  div_iter_unit_if #(.DATA_W(32)) bus ();
  div_iter_unit #(.DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Monitor: compare each new result against the oldest expected one.
  initial begin
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_done = 1'b0;
      end else begin
        if (bus.Div_Done && !prev_done) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done actual LO=0x%08h HI=0x%08h required no result",
                     bus.LO_Wdata, bus.HI_Wdata);
          end else begin
            e = sb_q.pop_front();
            if (bus.LO_Wdata !== e.lo || bus.HI_Wdata !== e.hi) begin
              errors++;
              $display("FAIL result actual LO=0x%08h HI=0x%08h required LO=0x%08h HI=0x%08h",
                       bus.LO_Wdata, bus.HI_Wdata, e.lo, e.hi);
            end
          end
        end
        prev_done = bus.Div_Done;
      end
    end
  end

  function automatic int exp_stall(input logic [31:0] rs, input logic [31:0] rt);
`ifdef DIV_ZERO_FAST_EN
    if (rs == 32'd0 || rt == 32'd0) return 1;
`endif
    return 33;
  endfunction

  // Called between a negedge and the next posedge with the FSM idle; leaves it idle the same way.
  task automatic run_div(input logic sgn, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] lo, input logic [31:0] hi, input int hold);
    int stall;
    exp_t e;
    e.lo = lo;
    e.hi = hi;
    sb_q.push_back(e);
    bus.EXE_IsDiv    = 1'b1;
    bus.EXE_IsSigned = sgn;
    bus.EXE_rs       = rs;
    bus.EXE_rt       = rt;
    bus.MEM_Wr       = 1'b0;
    #1;
    stall = 0;
    while (bus.DIVMULTBusy && stall < 100) begin
      stall++;
      @(negedge clk);
      #1;
    end
    chk("stall_cycles", 32'(stall), 32'(exp_stall(rs, rt)));
    chk("done_after_stall", {31'd0, bus.Div_Done}, 32'd1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      chk("hold_lo", bus.LO_Wdata, lo);
      chk("hold_hi", bus.HI_Wdata, hi);
      chk("hold_done", {31'd0, bus.Div_Done}, 32'd1);
      chk("hold_busy", {31'd0, bus.DIVMULTBusy}, 32'd0);
    end
    bus.MEM_Wr = 1'b1;
    @(negedge clk);
    #1;
    bus.MEM_Wr    = 1'b0;
    bus.EXE_IsDiv = 1'b0;
    #1;
    chk("idle_after_retire_done", {31'd0, bus.Div_Done}, 32'd0);
  endtask

  // Start an operation that will be aborted, and advance to its given BUSY cycle.
  task automatic start_to_busy(input logic [31:0] rs, input logic [31:0] rt, input int n);
    bus.EXE_IsDiv    = 1'b1;
    bus.EXE_IsSigned = 1'b0;
    bus.EXE_rs       = rs;
    bus.EXE_rt       = rt;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      #1;
    end
    chk("busy_before_abort", {31'd0, bus.DIVMULTBusy}, 32'd1);
  endtask

  task automatic expect_no_done(input int n);
    int seen;
    seen = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      #1;
      if (bus.Div_Done) seen++;
    end
    chk("no_done_after_abort", 32'(seen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.EXE_IsDiv       = 1'b0;
    bus.EXE_IsSigned    = 1'b0;
    bus.EXE_rs          = 32'd0;
    bus.EXE_rt          = 32'd0;
    bus.MEM_Wr          = 1'b0;
    bus.Flush_Exception = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", {31'd0, bus.DIVMULTBusy}, 32'd0);
    chk("rst_done", {31'd0, bus.Div_Done}, 32'd0);
    chk("rst_lo", bus.LO_Wdata, 32'd0);
    chk("rst_hi", bus.HI_Wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;

    run_div(1'b0, 32'd100,        32'd7,        32'd14,         32'd2,         0);
    run_div(1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD,  32'hFFFF_FFFF, 0);
    run_div(1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         0);
    run_div(1'b0, 32'd5,          32'd0,        32'hFFFF_FFFF,  32'd5,         0);
    run_div(1'b1, 32'hFFFF_FFFB,  32'd0,        32'd1,          32'hFFFF_FFFB, 0);
    run_div(1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         0);
    run_div(1'b0, 32'hFFFF_FFFF,  32'h10,       32'h0FFF_FFFF,  32'hF,         0);
    run_div(1'b1, 32'd0,          32'd5,        32'd0,          32'd0,         0);
    run_div(1'b0, 32'd0,          32'd0,        32'hFFFF_FFFF,  32'd0,         0);
    run_div(1'b0, 32'd1000,       32'd33,       32'd30,         32'd10,        4);

    // Flush in BUSY cycle 10: busy drops that cycle, nothing is reported.
    start_to_busy(32'd1000, 32'd3, 10);
    bus.Flush_Exception = 1'b1;
    #1;
    chk("flush_busy", {31'd0, bus.DIVMULTBusy}, 32'd0);
    @(negedge clk);
    #1;
    bus.Flush_Exception = 1'b0;
    bus.EXE_IsDiv       = 1'b0;
    #1;
    chk("flush_idle_busy", {31'd0, bus.DIVMULTBusy}, 32'd0);
    expect_no_done(40);
    run_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 0);

    // Flush together with start: no start.
    bus.EXE_IsDiv       = 1'b1;
    bus.Flush_Exception = 1'b1;
    #1;
    chk("flush_start_busy", {31'd0, bus.DIVMULTBusy}, 32'd0);
    @(negedge clk);
    #1;
    bus.EXE_IsDiv       = 1'b0;
    bus.Flush_Exception = 1'b0;
    expect_no_done(36);

    // Reset in BUSY cycle 20 clears every output at once.
    start_to_busy(32'd100, 32'd7, 20);
    rst           = 1'b1;
    bus.EXE_IsDiv = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, bus.DIVMULTBusy}, 32'd0);
    chk("midrst_done", {31'd0, bus.Div_Done}, 32'd0);
    chk("midrst_lo", bus.LO_Wdata, 32'd0);
    chk("midrst_hi", bus.HI_Wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    expect_no_done(36);
    run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
